// File: rtl/execute_mcycle_ctrl_pkg.sv
// Shared types for the multi-cycle execute controller.
// Holds the controller state enum and its register record with the reset value.
package execute_mcycle_ctrl_pkg;

  // Wide enough for any realistic channel count; the top uses only the low bits.
  localparam int UNIT_IDX_W = 8;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_WAIT  = 2'd1,
    MC_ABORT = 2'd2
  } mc_state_e;

  typedef struct packed {
    mc_state_e              state;
    logic [UNIT_IDX_W-1:0]  unit;
    logic [4:0]             waddr;
  } mc_ctrl_t;

  localparam mc_ctrl_t MC_CTRL_INIT = '{state: MC_IDLE, unit: '0, waddr: '0};

endpackage

// File: rtl/execute_mcycle_ctrl_timer.sv
// Saturating wait-cycle counter; hit is high while the count sits at LIMIT.
// Only instantiated when EXECUTE_MCYCLE_TIMEOUT_EN is defined.
module mcycle_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != W'(LIMIT))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign hit = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/execute_mcycle_ctrl.sv
// Multi-cycle execute controller: launches one unit, stalls until it is done,
// then writes back. Timeout logic is compiled in by EXECUTE_MCYCLE_TIMEOUT_EN.
module execute_mcycle_ctrl
  import execute_mcycle_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUNITS    = 4,
  parameter int TMO_LIMIT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [$clog2(NUNITS)-1:0]  issue_unit,
  input  logic [4:0]                 issue_waddr,
  input  logic                       clear,
  output logic                       issue_ready,
  output logic [NUNITS-1:0]          unit_enable,
  input  logic [NUNITS-1:0]          unit_ready,
  input  logic [NUNITS*XLEN-1:0]     unit_result,
  output logic                       stall,
  output logic                       wb_wren,
  output logic [4:0]                 wb_waddr,
  output logic [XLEN-1:0]            wb_wdata,
  output logic                       tmo_exception
);

  localparam int UW = $clog2(NUNITS);

  mc_ctrl_t         ctrl_q, ctrl_d;
  logic [UW-1:0]    unit_sel;
  logic             rdy_sel;
  logic [XLEN-1:0]  res_sel;
  logic             tmo_hit;

  assign unit_sel = ctrl_q.unit[UW-1:0];

  // Explicit compare-and-OR mux so a non-power-of-two NUNITS never indexes out of range.
  always_comb begin
    rdy_sel = 1'b0;
    res_sel = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (unit_sel == UW'(i)) begin
        rdy_sel = unit_ready[i];
        res_sel = unit_result[i*XLEN +: XLEN];
      end
    end
  end

`ifdef EXECUTE_MCYCLE_TIMEOUT_EN
  logic tmr_clr, tmr_en;

  assign tmr_clr = (ctrl_q.state == MC_IDLE) && issue_valid && !clear;
  assign tmr_en  = ((ctrl_q.state == MC_WAIT) || (ctrl_q.state == MC_ABORT)) && !rdy_sel;

  mcycle_timer #(.LIMIT(TMO_LIMIT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .hit (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    ctrl_d        = ctrl_q;
    issue_ready   = 1'b0;
    unit_enable   = '0;
    stall         = 1'b0;
    wb_wren       = 1'b0;
    wb_waddr      = '0;
    wb_wdata      = '0;
    tmo_exception = 1'b0;
    case (ctrl_q.state)
      MC_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && !clear) begin
          for (int i = 0; i < NUNITS; i++)
            unit_enable[i] = (issue_unit == UW'(i));
          stall        = 1'b1;
          ctrl_d.unit  = UNIT_IDX_W'(issue_unit);
          ctrl_d.waddr = issue_waddr;
          ctrl_d.state = MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (clear) begin
          ctrl_d.state = rdy_sel ? MC_IDLE : MC_ABORT;
        end else if (rdy_sel) begin
          wb_wren      = |ctrl_q.waddr;
          wb_waddr     = ctrl_q.waddr;
          wb_wdata     = wb_wren ? res_sel : '0;
          ctrl_d.state = MC_IDLE;
        end else if (tmo_hit) begin
          tmo_exception = 1'b1;
          ctrl_d.state  = MC_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      MC_ABORT: begin
        // The flushed op's result is drained and dropped here.
        if (rdy_sel || tmo_hit)
          ctrl_d.state = MC_IDLE;
      end
      default: ctrl_d = MC_CTRL_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= MC_CTRL_INIT;
    else     ctrl_q <= ctrl_d;
  end

endmodule

// File: tb/tb_execute_mcycle_ctrl.sv
// Directed self-checking bench for execute_mcycle_ctrl (XLEN=32, NUNITS=4, TMO_LIMIT=4).
module tb_execute_mcycle_ctrl;

  localparam int XLEN = 32;
  localparam int NU   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [1:0]        issue_unit;
  logic [4:0]        issue_waddr;
  logic              clear;
  logic              issue_ready;
  logic [NU-1:0]     unit_enable;
  logic [NU-1:0]     unit_ready;
  logic [NU*XLEN-1:0] unit_result;
  logic              stall;
  logic              wb_wren;
  logic [4:0]        wb_waddr;
  logic [XLEN-1:0]   wb_wdata;
  logic              tmo_exception;

  int n_tests = 0;
  int n_fail  = 0;

  execute_mcycle_ctrl #(.XLEN(XLEN), .NUNITS(NU), .TMO_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_unit    (issue_unit),
    .issue_waddr   (issue_waddr),
    .clear         (clear),
    .issue_ready   (issue_ready),
    .unit_enable   (unit_enable),
    .unit_ready    (unit_ready),
    .unit_result   (unit_result),
    .stall         (stall),
    .wb_wren       (wb_wren),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .tmo_exception (tmo_exception)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle inputs just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_unit  = '0;
    issue_waddr = '0;
    clear       = 1'b0;
    unit_ready  = '0;
  endtask

  task automatic issue(input logic [1:0] u, input logic [4:0] wa);
    issue_valid = 1'b1;
    issue_unit  = u;
    issue_waddr = wa;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_tests++; if (wb_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b exp 0", wb_wren); end
    n_tests++; if (unit_enable !== 4'b0000) begin n_fail++; $display("FAIL reset_enable got %b exp 0000", unit_enable); end
    n_tests++; if (tmo_exception !== 1'b0) begin n_fail++; $display("FAIL reset_tmo got %b exp 0", tmo_exception); end
  endtask

  task automatic test_writeback();
    step();
    issue(2'd1, 5'd5);
    @(negedge clk);
    n_tests++; if (unit_enable !== 4'b0010) begin n_fail++; $display("FAIL wb_enable got %b exp 0010", unit_enable); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wb_stall_issue got %b exp 1", stall); end
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++; if ({issue_ready, stall, unit_enable} !== 6'b0_1_0000) begin n_fail++; $display("FAIL wb_wait1 got %b exp 010000", {issue_ready, stall, unit_enable}); end
    step();
    @(negedge clk);
    n_tests++; if ({stall, wb_wren} !== 2'b10) begin n_fail++; $display("FAIL wb_wait2 got %b exp 10", {stall, wb_wren}); end
    step();
    unit_ready = 4'b0010;
    @(negedge clk);
    n_tests++; if ({wb_wren, stall} !== 2'b10) begin n_fail++; $display("FAIL wb_ready_ctl got %b exp 10", {wb_wren, stall}); end
    n_tests++; if (wb_waddr !== 5'd5) begin n_fail++; $display("FAIL wb_waddr got %0d exp 5", wb_waddr); end
    n_tests++; if (wb_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_wdata got %h exp deadbeef", wb_wdata); end
    step();
    unit_ready = '0;
    @(negedge clk);
    n_tests++; if ({issue_ready, wb_wren} !== 2'b10) begin n_fail++; $display("FAIL wb_after got %b exp 10", {issue_ready, wb_wren}); end
  endtask

  task automatic test_waddr_zero();
    step();
    issue(2'd3, 5'd0);
    step();
    idle_inputs();
    unit_ready = 4'b1000;
    @(negedge clk);
    n_tests++; if ({wb_wren, stall} !== 2'b00) begin n_fail++; $display("FAIL x0_ctl got %b exp 00", {wb_wren, stall}); end
    n_tests++; if (wb_wdata !== 32'h0) begin n_fail++; $display("FAIL x0_wdata got %h exp 0", wb_wdata); end
    step();
    unit_ready = '0;
    @(negedge clk);
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_idle got %b exp 1", issue_ready); end
  endtask

  task automatic test_clear_idle();
    step();
    issue(2'd2, 5'd6);
    clear = 1'b1;
    @(negedge clk);
    n_tests++; if ({unit_enable, stall} !== 5'b0000_0) begin n_fail++; $display("FAIL clridle got %b exp 00000", {unit_enable, stall}); end
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL clridle_ready got %b exp 1", issue_ready); end
  endtask

  task automatic test_abort();
    step();
    issue(2'd2, 5'd7);
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL abort_w1 got %b exp 1", stall); end
    step();
    clear = 1'b1;
    @(negedge clk);
    n_tests++; if ({stall, wb_wren} !== 2'b00) begin n_fail++; $display("FAIL abort_clr got %b exp 00", {stall, wb_wren}); end
    step();
    clear = 1'b0;
    issue(2'd1, 5'd8);
    @(negedge clk);
    n_tests++; if ({issue_ready, stall, unit_enable} !== 6'b0_0_0000) begin n_fail++; $display("FAIL abort_ign got %b exp 000000", {issue_ready, stall, unit_enable}); end
    step();
    unit_ready = 4'b0010;
    @(negedge clk);
    n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL abort_wrong got %b exp 0", issue_ready); end
    step();
    unit_ready = 4'b0100;
    @(negedge clk);
    n_tests++; if ({wb_wren, stall, unit_enable} !== 6'b0_0_0000) begin n_fail++; $display("FAIL abort_drain got %b exp 000000", {wb_wren, stall, unit_enable}); end
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle got %b exp 1", issue_ready); end
  endtask

  task automatic test_wrong_unit();
    step();
    issue(2'd0, 5'd9);
    step();
    idle_inputs();
    unit_ready = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++; if ({stall, wb_wren, issue_ready} !== 3'b100) begin n_fail++; $display("FAIL wrong_unit_w%0d got %b exp 100", k, {stall, wb_wren, issue_ready}); end
      step();
    end
    unit_ready = 4'b0001;
    @(negedge clk);
    n_tests++; if ({wb_wren, wb_waddr, wb_wdata} !== {1'b1, 5'd9, 32'h0BADF00D}) begin n_fail++; $display("FAIL wrong_unit_wb got %b/%0d/%h exp 1/9/0badf00d", wb_wren, wb_waddr, wb_wdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_clear_with_ready();
    step();
    issue(2'd1, 5'd12);
    step();
    idle_inputs();
    clear = 1'b1;
    unit_ready = 4'b0010;
    @(negedge clk);
    n_tests++; if ({wb_wren, stall} !== 2'b00) begin n_fail++; $display("FAIL clrrdy got %b exp 00", {wb_wren, stall}); end
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL clrrdy_idle got %b exp 1", issue_ready); end
  endtask

  task automatic test_back_to_back();
    step();
    issue(2'd2, 5'd10);
    step();
    idle_inputs();
    unit_ready = 4'b0100;
    @(negedge clk);
    n_tests++; if ({wb_wren, wb_waddr, wb_wdata} !== {1'b1, 5'd10, 32'hC0FFEE02}) begin n_fail++; $display("FAIL b2b_first got %b/%0d/%h exp 1/10/c0ffee02", wb_wren, wb_waddr, wb_wdata); end
    step();
    unit_ready = '0;
    issue(2'd3, 5'd11);
    @(negedge clk);
    n_tests++; if ({issue_ready, unit_enable} !== 5'b1_1000) begin n_fail++; $display("FAIL b2b_issue got %b exp 11000", {issue_ready, unit_enable}); end
    step();
    idle_inputs();
    unit_ready = 4'b1000;
    @(negedge clk);
    n_tests++; if ({wb_wren, wb_waddr} !== {1'b1, 5'd11}) begin n_fail++; $display("FAIL b2b_second got %b/%0d exp 1/11", wb_wren, wb_waddr); end
    step();
    idle_inputs();
  endtask

`ifdef EXECUTE_MCYCLE_TIMEOUT_EN
  task automatic test_timeout();
    step();
    issue(2'd1, 5'd3);
    step();
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_tests++; if ({tmo_exception, stall, wb_wren} !== {k == 5, k != 5, 1'b0}) begin n_fail++; $display("FAIL tmo_w%0d got %b exp %b", k, {tmo_exception, stall, wb_wren}, {k == 5, k != 5, 1'b0}); end
      step();
    end
    @(negedge clk);
    n_tests++; if ({issue_ready, tmo_exception} !== 2'b10) begin n_fail++; $display("FAIL tmo_after got %b exp 10", {issue_ready, tmo_exception}); end
  endtask
`else
  task automatic test_timeout();
    step();
    issue(2'd1, 5'd3);
    step();
    idle_inputs();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_tests++; if ({tmo_exception, stall} !== 2'b01) begin n_fail++; $display("FAIL notmo_w%0d got %b exp 01", k, {tmo_exception, stall}); end
      step();
    end
    unit_ready = 4'b0010;
    @(negedge clk);
    n_tests++; if ({wb_wren, wb_waddr} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL notmo_wb got %b/%0d exp 1/3", wb_wren, wb_waddr); end
    step();
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid();
    step();
    issue(2'd1, 5'd4);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    unit_ready = 4'b0010;
    @(negedge clk);
    n_tests++; if ({wb_wren, stall, issue_ready} !== 3'b001) begin n_fail++; $display("FAIL rstmid got %b exp 001", {wb_wren, stall, issue_ready}); end
    step();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle got %b exp 1", issue_ready); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    unit_result = {32'hC0FFEE03, 32'hC0FFEE02, 32'hDEADBEEF, 32'h0BADF00D};
    test_reset();
    test_writeback();
    unit_result[3*XLEN +: XLEN] = 32'h00001234;
    test_waddr_zero();
    unit_result[3*XLEN +: XLEN] = 32'hC0FFEE03;
    test_clear_idle();
    test_abort();
    test_wrong_unit();
    test_clear_with_ready();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mcycle_ctrl.md
EXECUTE_MCYCLE_CTRL -- requirements
Module: execute_mcycle_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: result data width.
REQ-002 SHALL have parameter NUNITS, default 4: number of multi-cycle unit channels (div, lsu, ...); minimum 2.
REQ-003 SHALL have parameter TMO_LIMIT, default 255: timeout in wait cycles; counter width $clog2(TMO_LIMIT+1).
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as the codebase does.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  multi-cycle op presented.
- issue_unit  in  $clog2(NUNITS)  target channel.
- issue_waddr  in  5  destination register.
- clear  in  1  pipeline flush.
- issue_ready  out  1  controller idle.
- unit_enable  out  NUNITS  one-hot start pulse.
- unit_ready  in  NUNITS  per-channel done.
- unit_result  in  NUNITS*XLEN  packed per-channel results; channel i at [i*XLEN +: XLEN].
- stall  out  1  hold the upstream stage.
- wb_wren  out  1  register write enable.
- wb_waddr  out  5  register write address.
- wb_wdata  out  XLEN  register write data.
- tmo_exception  out  1  timeout pulse.

Function
REQ-006 SHALL implement states IDLE, WAIT and ABORT; issue_ready SHALL be 1 only in IDLE.
REQ-007 In IDLE, with issue_valid=1 and clear=0:
- unit_enable[issue_unit]=1 and stall=1 in the same cycle, combinationally.
- issue_unit and issue_waddr latched.
- counter cleared; next state WAIT.
REQ-008 In IDLE, with issue_valid=1 and clear=1: clear wins; no enable, stall=0, stay in IDLE.
REQ-009 In WAIT, with unit_ready[u]=1 for the latched channel u and clear=0, in the same cycle:
- wb_wren = |waddr.
- wb_waddr = latched waddr.
- wb_wdata = unit_result channel u.
- stall=0; next state IDLE.
REQ-010 In WAIT, without ready: stall=1, counter increments (saturating); next state WAIT.
REQ-011 In WAIT, with clear=1:
- stall=0 and wb_wren=0.
- If unit_ready[u]=1 the same cycle: next state IDLE; otherwise next state ABORT.
REQ-012 In ABORT: stall=0, wb_wren=0, issue_valid ignored; unit_ready[u]=1 returns to IDLE with the result discarded.
REQ-013 unit_ready of non-latched channels, and any unit_ready in IDLE, SHALL be ignored.
REQ-014 unit_enable SHALL be a single-cycle pulse with at most one bit set; minimum issue-to-writeback latency is 2 cycles.
REQ-015 wb_wren, wb_waddr, wb_wdata and stall SHALL be combinational, so writeback and forwarding happen in the ready cycle.
REQ-016 When no writeback occurs, wb_wren=0 and wb_wdata=0.

Reset
REQ-017 On rst=1 at a clock edge:
- state IDLE, counter 0, latched unit and waddr 0.
- In the following cycle, with no issue: stall=0, wb_wren=0, unit_enable=0, tmo_exception=0, issue_ready=1.
REQ-018 Reset mid-operation SHALL abandon the op with no writeback; a later unit_ready SHALL be ignored.

Configuration
REQ-019 Macro EXECUTE_MCYCLE_TIMEOUT_EN SHALL compile in the timeout logic.
REQ-020 With EXECUTE_MCYCLE_TIMEOUT_EN defined:
- In WAIT, counter==TMO_LIMIT with no ready: tmo_exception=1 for one cycle, stall=0, no writeback, next state IDLE.
- In ABORT, the same condition returns silently to IDLE.
REQ-021 Without EXECUTE_MCYCLE_TIMEOUT_EN: no counter, tmo_exception tied 0, and WAIT/ABORT wait indefinitely.

Structure
REQ-022 The state enum (IDLE/WAIT/ABORT) and the controller register record type with its init constant SHALL be placed in the shared wires package.
REQ-023 The timeout counter SHALL be a sub-module mcycle_timer (clear, enable, saturate, hit output), instantiated only under EXECUTE_MCYCLE_TIMEOUT_EN.

Verification
REQ-024 Issue unit 1, waddr 5; unit_ready[1] on the 3rd WAIT cycle with result 0xDEADBEEF -> stall high for 3 cycles, then wb_wren=1, waddr 5, wdata 0xDEADBEEF in the ready cycle.
REQ-025 Issue with waddr 0; unit ready with result 0x1234 -> wb_wren=0, stall drops, state IDLE.
REQ-026 Issue unit 2; clear in 2nd WAIT cycle -> stall=0; issue_valid ignored until unit_ready[2]; no writeback; then issue_ready=1.
REQ-027 Issue unit 0; unit_ready[3]=1 only -> remains in WAIT with stall=1 and no writeback.
REQ-028 Macro defined, TMO_LIMIT=4, unit never ready -> tmo_exception pulses once, 5 WAIT cycles after the issue cycle; then issue_ready=1.
REQ-029 Reset asserted during WAIT, then a late unit_ready -> no writeback, issue_ready=1.
